// File: rtl/psg_pkg.sv
// Shared PSG attenuation constants and the code -> linear level function (-2dB/step, code 15 silent).
// Latency: n/a (package). Backpressure: n/a.
// Levels are floor(MAX * 10^(-k/10)) with a floor of 1, from 12-digit truncated decimal fractions.
package psg_pkg;

  localparam int               ATTEN_W      = 4;
  localparam int               ATTEN_CODES  = 16;
  localparam logic [ATTEN_W-1:0] ATTEN_SILENT = 4'd15;

  localparam logic [63:0] FRAC_SCALE = 64'd1_000_000_000_000;

  // 10^(-k/10) scaled by 1e12 and truncated; truncation keeps the product at or below the true value
  localparam logic [63:0] ATTEN_FRAC [ATTEN_CODES] = '{
    64'd1_000_000_000_000,
    64'd794_328_234_724,
    64'd630_957_344_480,
    64'd501_187_233_627,
    64'd398_107_170_553,
    64'd316_227_766_016,
    64'd251_188_643_150,
    64'd199_526_231_496,
    64'd158_489_319_246,
    64'd125_892_541_179,
    64'd100_000_000_000,
    64'd79_432_823_472,
    64'd63_095_734_448,
    64'd50_118_723_362,
    64'd39_810_717_055,
    64'd0
  };

  function automatic logic [31:0] atten_level(input logic [ATTEN_W-1:0] code, input int vbits);
    logic [63:0] max_v;
    logic [63:0] lvl;
    max_v = (64'd1 << vbits) - 64'd1;
    if (code == ATTEN_SILENT) begin
      lvl = '0;
    end else if (code == '0) begin
      lvl = max_v;
    end else begin
      lvl = (max_v * ATTEN_FRAC[code]) / FRAC_SCALE;
      if (lvl == '0) lvl = 64'd1;
    end
    return lvl[31:0];
  endfunction

endpackage

// File: rtl/attenuation_lut.sv
// Combinational attenuation code -> linear level lookup, table built at elaboration.
// Latency: 0 cycles. Backpressure: none (pure function of code).
module attenuation_lut
  import psg_pkg::*;
#(
  parameter int VOLUME_BITS = 14
) (
  input  logic [ATTEN_W-1:0]     code,
  output logic [VOLUME_BITS-1:0] level
);

  logic [VOLUME_BITS-1:0] table_w [ATTEN_CODES];

  for (genvar g = 0; g < ATTEN_CODES; g++) begin : g_entry
    localparam logic [31:0] LVL = atten_level(ATTEN_W'(g), VOLUME_BITS);
    assign table_w[g] = LVL[VOLUME_BITS-1:0];
  end

  assign level = table_w[code];

endmodule

// File: rtl/attenuation_mixer.sv
// Time-multiplexed N-channel attenuate-and-sum; one slot per channel, one summed sample per frame.
// Latency: out/out_valid update on the N-th edge of each frame. Backpressure: none, free-running.
// Optional ATTENUATION_RAMP_EN: per-channel codes step one unit toward control every RAMP_DIV frames.
module attenuation_mixer
  import psg_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int CONTROL_BITS = 4,
  parameter  int VOLUME_BITS  = 14,
  parameter  int RAMP_DIV     = 16,
  localparam int OUT_BITS     = VOLUME_BITS + $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            in,
  input  logic [NUM_CHANNELS*CONTROL_BITS-1:0] control,
  output logic [OUT_BITS-1:0]                out,
  output logic                               out_valid
);

  localparam int              CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  logic [CH_W-1:0]        ch;
  logic                   last_slot;
  logic [OUT_BITS-1:0]    acc;
  logic [OUT_BITS-1:0]    sum;
  logic [ATTEN_W-1:0]     tgt_code;
  logic [ATTEN_W-1:0]     eff_code;
  logic [VOLUME_BITS-1:0] lut_level;
  logic [VOLUME_BITS-1:0] level;

  assign last_slot = (ch == LAST_CH);
  assign tgt_code  = ATTEN_W'(control[int'(ch)*CONTROL_BITS +: CONTROL_BITS]);

  attenuation_lut #(
    .VOLUME_BITS(VOLUME_BITS)
  ) u_lut (
    .code (eff_code),
    .level(lut_level)
  );

  assign level = in[ch] ? lut_level : '0;
  assign sum   = acc + OUT_BITS'(level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= last_slot;
      if (last_slot) begin
        ch  <= '0;
        acc <= '0;
        out <= sum;
      end else begin
        ch  <= ch + 1'b1;
        acc <= sum;
      end
    end
  end

`ifdef ATTENUATION_RAMP_EN
  localparam int FCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [FCNT_W-1:0]  fcnt;
  logic               ramp_tick;
  logic [ATTEN_W-1:0] cur [NUM_CHANNELS];

  // Frame 0 after reset is a tick frame, so a ramp starts moving immediately
  assign ramp_tick = (fcnt == '0);
  assign eff_code  = cur[ch];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
    end else if (last_slot) begin
      fcnt <= (fcnt == FCNT_W'(RAMP_DIV - 1)) ? '0 : fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) cur[k] <= ATTEN_SILENT;
    end else if (ramp_tick) begin
      if (cur[ch] < tgt_code)      cur[ch] <= cur[ch] + 1'b1;
      else if (cur[ch] > tgt_code) cur[ch] <= cur[ch] - 1'b1;
    end
  end
`else
  logic ramp_div_unused;

  assign eff_code        = tgt_code;
  assign ramp_div_unused = (RAMP_DIV > 0);
`endif

endmodule
